// File: rtl/prbs4_pkg.sv
// Shared constants, state type and tap function for the PRBS4 generator/checker pair.
// The generator shifts left and inserts st[TAP_HI] ^ st[TAP_LO] as the new LSB.
package prbs4_pkg;

    localparam int PRBS_W = 4;
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 1;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 4'b1110;

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCKED
    } chk_state_t;

    function automatic logic prbs_feedback(input logic [PRBS_W-1:0] st);
        return st[TAP_HI] ^ st[TAP_LO];
    endfunction

endpackage

// File: rtl/prbs4_step.sv
// One combinational step of the PRBS4 register: predicted next bit and the shifted state.
module prbs4_step
    import prbs4_pkg::*;
(
    input  logic [PRBS_W-1:0] state,
    output logic              next_bit,
    output logic [PRBS_W-1:0] next_state
);

    assign next_bit   = prbs_feedback(state);
    assign next_state = {state[PRBS_W-2:0], next_bit};

endmodule

// File: rtl/prbs4_checker.sv
// Self-synchronising PRBS4 checker: fills and hunts on the received bits, then
// free-runs a local copy of the generator and counts mismatches while locked.
module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int LOCK_CNT  = 8,
    parameter int WIN_LEN   = 16,
    parameter int LOSS_ERRS = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 din_valid,
    input  logic                 din,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(PRBS_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WBIT_W  = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS_W - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERRS - 1);

    chk_state_t state;
    chk_state_t next_state;

    logic [PRBS_W-1:0]  s;
    logic [PRBS_W-1:0]  l;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WBIT_W-1:0]  win_bits;
    logic [WERR_W-1:0]  win_err;

    logic              rx_bit;
    logic [PRBS_W-1:0] rx_next;
    logic              lc_bit;
    logic [PRBS_W-1:0] lc_next;

    logic [PRBS_W-1:0] s_shift;
    logic              rx_match;
    logic              lc_err;
    logic              err_hit;
    logic              locked_nxt;

    // Prediction from the received history (hunting) and from the local free-running copy (locked).
    prbs4_step u_rx_step (
        .state      (s),
        .next_bit   (rx_bit),
        .next_state (rx_next)
    );

    prbs4_step u_lc_step (
        .state      (l),
        .next_bit   (lc_bit),
        .next_state (lc_next)
    );

    assign s_shift  = {s[PRBS_W-2:0], din};
    // All-zero history is the generator lock-up state and must never count as a match.
    assign rx_match = (din == rx_bit) && (s != '0);
    assign lc_err   = (din != lc_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (din_valid) begin
            unique case (state)
                FILL:    if (fill_cnt == FILL_LAST) next_state = HUNT;
                HUNT:    if (rx_match && (match_cnt == MATCH_LAST)) next_state = LOCKED;
                LOCKED:  if (lc_err && (win_err == WERR_LAST)) next_state = FILL;
                default: next_state = FILL;
            endcase
        end
    end

    always_comb begin
        err_hit    = din_valid && (state == LOCKED) && lc_err;
        locked_nxt = (next_state == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            l         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            locked    <= locked_nxt;
            err_pulse <= err_hit;

            // Clear beats a coincident error; the counter sticks at all-ones.
            if (clr) begin
                err_cnt <= '0;
            end else if (err_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end

            if (din_valid) begin
                case (state)
                    FILL: begin
                        s         <= s_shift;
                        match_cnt <= '0;
                        fill_cnt  <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + FILL_W'(1);
                    end
                    HUNT: begin
                        s <= s_shift;
                        if (!rx_match) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            match_cnt <= '0;
                            l         <= rx_next;
                            win_bits  <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    LOCKED: begin
                        l <= lc_next;
                        // Loss of lock is decided before the window boundary wipes the error tally.
                        if (next_state == FILL) begin
                            s        <= '0;
                            fill_cnt <= '0;
                            win_bits <= '0;
                            win_err  <= '0;
                        end else if (win_bits == WBIT_LAST) begin
                            win_bits <= '0;
                            win_err  <= '0;
                        end else begin
                            win_bits <= win_bits + WBIT_W'(1);
                            if (lc_err) begin
                                win_err <= win_err + WERR_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// Randomised bench for prbs4_checker: a bit-history reference model predicts lock,
// error pulses and saturating error counts for a 16-bit and a 4-bit counter instance.
module tb_prbs4_checker;

    localparam int LOCK_CNT  = 8;
    localparam int WIN_LEN   = 16;
    localparam int LOSS_ERRS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic din_valid = 1'b0;
    logic din = 1'b0;

    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        locked4, err_pulse4;
    logic [3:0]  err_cnt4;
    logic [23:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prbs4_checker dut (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prbs4_checker #(.ERR_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
    );

    assign obs = {locked, err_pulse, err_cnt, locked4, err_pulse4, err_cnt4};

    bit pat [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int phase = 0;

    // Reference model: mode 0 fill, 1 hunt, 2 locked; queues hold the last four bits, oldest first.
    int m_mode, m_match, m_wbits, m_werr, m_errs;
    bit m_locked, m_pulse;
    bit rx_q [$];
    bit lc_q [$];

    function automatic void model_reset();
        m_mode = 0; m_match = 0; m_wbits = 0; m_werr = 0; m_errs = 0;
        m_locked = 1'b0; m_pulse = 1'b0;
        rx_q.delete(); lc_q.delete();
    endfunction

    function automatic void model_step(input bit v, input bit d, input bit c);
        bit pred, zero;
        m_pulse = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                rx_q.push_back(d);
                if (rx_q.size() == 4) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                zero = !(rx_q[0] | rx_q[1] | rx_q[2] | rx_q[3]);
                pred = rx_q[0] ^ rx_q[2];
                rx_q.push_back(d);
                void'(rx_q.pop_front());
                if (zero || d != pred) m_match = 0;
                else m_match++;
                if (m_match == LOCK_CNT) begin
                    m_mode = 2; lc_q = rx_q; m_wbits = 0; m_werr = 0;
                end
            end else begin
                pred = lc_q[0] ^ lc_q[2];
                lc_q.push_back(pred);
                void'(lc_q.pop_front());
                m_wbits++;
                if (d != pred) begin m_pulse = 1'b1; m_errs++; m_werr++; end
                if (m_werr == LOSS_ERRS) begin
                    m_mode = 0; rx_q.delete();
                end else if (m_wbits == WIN_LEN) begin
                    m_wbits = 0; m_werr = 0;
                end
            end
        end
        if (c) m_errs = 0;
        m_locked = (m_mode == 2);
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
        c4  = (m_errs > 15) ? 4'hF : 4'(m_errs);
        return {m_locked, m_pulse, c16, m_locked, m_pulse, c4};
    endfunction

    function automatic bit next_clean();
        bit b;
        b = pat[phase];
        phase = (phase + 1) % 6;
        return b;
    endfunction

    task automatic cycle(input bit v, input bit d, input bit c);
        din_valid = v; din = d; clr = c;
        model_step(v, d, c);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        phase = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("[TB] FAIL reset_state: got %h expected %h", obs, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        int n = 0;
        do_reset();
        for (int i = 0; i < 30 && !locked; i++) begin
            cycle(1'b1, next_clean(), 1'b0);
            n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("[TB] FAIL lock_cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (n != 12) begin
            errors++; $display("[TB] FAIL lock_latency: got %0d bits expected 12", n);
        end
    endtask

    task automatic test_single_error();
        int pos = $urandom_range(3, 15);
        int pulses = 0;
        for (int i = 0; i < 40; i++) begin
            bit b;
            b = next_clean();
            if (i == pos) b = ~b;
            cycle(1'b1, b, 1'b0);
            if (err_pulse) pulses++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("[TB] FAIL single_err_cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (pulses != 1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_err_summary: got pulses=%0d cnt=%0d locked=%b expected 1 1 1",
                     pulses, err_cnt, locked);
        end
    endtask

    task automatic test_loss();
        int p [4];
        int n = 0;
        cycle(1'b1, next_clean(), 1'b1);
        for (int i = 0; i < WIN_LEN && m_wbits != 0; i++) cycle(1'b1, next_clean(), 1'b0);
        p[0] = $urandom_range(0, 3);
        for (int k = 1; k < 4; k++) p[k] = p[k-1] + $urandom_range(1, 3);
        for (int i = 0; i <= p[3]; i++) begin
            bit b;
            b = next_clean();
            if (i == p[0] || i == p[1] || i == p[2] || i == p[3]) b = ~b;
            cycle(1'b1, b, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("[TB] FAIL loss_cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd4 || err_pulse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loss_of_lock: got locked=%b cnt=%0d pulse=%b expected 0 4 1",
                     locked, err_cnt, err_pulse);
        end
        for (int i = 0; i < 30 && !locked; i++) begin
            cycle(1'b1, next_clean(), 1'b0);
            n++;
        end
        checks++;
        if (n != 12) begin
            errors++; $display("[TB] FAIL relock_latency: got %0d bits expected 12", n);
        end

        cycle(1'b1, next_clean(), 1'b1);
        for (int i = 0; i < WIN_LEN && m_wbits != 0; i++) cycle(1'b1, next_clean(), 1'b0);
        for (int w = 0; w < 3; w++) begin
            int a, bb, cc;
            a  = $urandom_range(0, 4);
            bb = a + $urandom_range(1, 5);
            cc = bb + $urandom_range(1, 5);
            for (int i = 0; i < WIN_LEN; i++) begin
                bit b;
                b = next_clean();
                if (i == a || i == bb || i == cc) b = ~b;
                cycle(1'b1, b, 1'b0);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("[TB] FAIL three_per_win w%0d i%0d: got %h expected %h", w, i, obs, exp_vec());
                end
            end
        end
        checks++;
        if (err_cnt !== 16'd9 || locked !== 1'b1) begin
            errors++; $display("[TB] FAIL three_per_win_total: got cnt=%0d locked=%b expected 9 1", err_cnt, locked);
        end
    endtask

    task automatic test_lockup_gaps();
        bit seen = 1'b0;
        int nv = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (locked) seen = 1'b1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("[TB] FAIL zero_stream %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (seen) begin
            errors++; $display("[TB] FAIL zero_lockup: got locked=1 expected 0");
        end
        do_reset();
        for (int i = 0; i < 60 && !locked; i++) begin
            bit v, d;
            v = (i % 3 == 0);
            d = v ? next_clean() : bit'($urandom_range(0, 1));
            cycle(v, d, 1'b0);
            if (v) nv++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("[TB] FAIL gap_cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (nv != 12 || locked !== 1'b1) begin
            errors++; $display("[TB] FAIL gap_lock: got %0d valid bits locked=%b expected 12 1", nv, locked);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 30 && !locked; i++) cycle(1'b1, next_clean(), 1'b0);
        for (int i = 0; i < WIN_LEN && m_wbits != 0; i++) cycle(1'b1, next_clean(), 1'b0);
        for (int w = 0; w < 20; w++) begin
            int pos;
            pos = $urandom_range(0, WIN_LEN - 1);
            for (int i = 0; i < WIN_LEN; i++) begin
                bit b;
                b = next_clean();
                if (i == pos) b = ~b;
                cycle(1'b1, b, 1'b0);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("[TB] FAIL sat_cycle w%0d i%0d: got %h expected %h", w, i, obs, exp_vec());
                end
            end
        end
        checks++;
        if (err_cnt4 !== 4'd15 || err_cnt !== 16'd20 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturation: got cnt4=%0d cnt16=%0d locked=%b expected 15 20 1",
                     err_cnt4, err_cnt, locked);
        end
        cycle(1'b1, ~next_clean(), 1'b1);
        checks++;
        if (err_cnt !== 16'd0 || err_cnt4 !== 4'd0 || err_pulse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_with_error: got cnt16=%0d cnt4=%0d pulse=%b expected 0 0 1",
                     err_cnt, err_cnt4, err_pulse);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        cycle(1'b1, ~next_clean(), 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("[TB] FAIL pre_async: got %h expected %h", obs, exp_vec());
        end
        din_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd0 || err_cnt4 !== 4'd0 || err_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got locked=%b cnt=%0d cnt4=%0d pulse=%b expected 0 0 0 0",
                     locked, err_cnt, err_cnt4, err_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30 && !locked; i++) begin
            cycle(1'b1, next_clean(), 1'b0);
            n++;
        end
        checks++;
        if (n != 12) begin
            errors++; $display("[TB] FAIL async_relock: got %0d bits expected 12", n);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit v, d, c;
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                d = next_clean();
                if ($urandom_range(0, 19) == 0) d = ~d;
            end else begin
                d = bit'($urandom_range(0, 1));
            end
            c = ($urandom_range(0, 49) == 0);
            cycle(v, d, c);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("[TB] FAIL random_cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_lockup_gaps();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs4_checker.md
Name: prbs4_checker

Overview:
- Downstream consumer of the 4-bit feedback shift register stage (PRBS generator).
- The generator next-state is {sr[2:0], sr[3]^sr[1]}, seed 4'b1110.
- This block receives the generator's serial output bit (out[0], the newly inserted bit), self-synchronises to the sequence, then counts bit errors and declares lock and loss-of-lock.
- Used for link and loopback self-test of the generator path.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions in HUNT required to declare lock.
- WIN_LEN, 16: length of the loss-of-lock observation window, in valid bits.
- LOSS_ERRS, 4: errors within one window that force loss of lock.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- clr  in  1  synchronous clear of err_cnt only.
- din_valid  in  1  din is sampled this cycle.
- din  in  1  received serial PRBS bit.
- locked  out  1  checker is in LOCKED state (registered).
- err_pulse  out  1  one-cycle pulse: the previous valid bit mismatched while LOCKED.
- err_cnt  out  ERR_CNT_W  saturating count of errors while LOCKED.

Behaviour:
- Reset (rst=1, async): state=FILL, shift reg s=0, local state l=0, fill/match/window counters=0, locked=0, err_pulse=0, err_cnt=0. Reset mid-operation aborts lock immediately.
- din_valid=0: no state, register or counter changes; err_pulse=0 next cycle.
- All outputs are registered; they reflect a valid bit one cycle after it is sampled.
- pred = s[3]^s[1] (HUNT) or l[3]^l[1] (LOCKED), i.e. the same taps as the generator.
- FILL: each valid bit does s <= {s[2:0],din}. After the 4th valid bit -> HUNT, match_cnt=0.
- HUNT: each valid bit does s <= {s[2:0],din}.
  - If s==4'b0000 or din!=pred: match_cnt=0. All-zero is the lock-up state and must never lock.
  - Else match_cnt++.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, set l <= {s[2:0],din}, clear window counters.
  - locked=1 from the next cycle.
- LOCKED: l <= {l[2:0],pred}, free-running from local state, so received errors do not propagate.
  - On mismatch: err_pulse=1 next cycle; err_cnt++ (saturates at all-ones, no wrap); win_err++.
  - win_bits counts valid bits. On the WIN_LEN-th bit, win_bits=0 and win_err=0 (a mismatch on that same bit still counts toward the current window first).
  - When win_err reaches LOSS_ERRS: go to FILL, s=0, locked=0 next cycle. err_pulse and err_cnt still register that error.
- HUNT/FILL: no err_pulse, no err_cnt change.
- clr=1: err_cnt=0 next cycle. clr wins over a simultaneous error increment; err_pulse is unaffected.
- Sequence from seed 1110 (din stream): 0,1,1,1,1,0 repeating, period 6 (the taps are not maximal-length; this is intended).

Decomposition:
- Package prbs4_pkg:
  - PRBS_W=4.
  - Tap indices TAP_HI=3, TAP_LO=1.
  - PRBS_SEED=4'b1110.
  - State enum {FILL, HUNT, LOCKED}.
- Sub-module prbs4_step (combinational): state in -> next bit and next state.
  - Instantiated twice: once for received-state prediction, once for the local-state advance.
  - The generator can share it.

Test Plan:
- Lock acquisition: after reset, drive the repeating stream 0,1,1,1,1,0 with din_valid=1 continuously -> locked rises the cycle after valid bit 12 (4 fill + 8 matches); err_cnt=0; no err_pulse.
- Single error: once locked, invert one bit -> exactly one err_pulse, err_cnt=1, locked stays 1, and subsequent bits produce no further errors (no error multiplication).
- Loss of lock: invert 4 bits within one 16-bit window -> err_cnt=4, locked falls the cycle after the 4th error; resuming the clean stream relocks after 12 more valid bits. Also: 3 errors per window over 3 windows -> stays locked, err_cnt=9.
- Lock-up and valid gaps: an all-zero stream for 100 bits -> locked never asserts. A clean stream with din_valid toggling 1,0,0,1,... -> locks after 12 valid bits, and state is unchanged during idle cycles.
- Saturation and clear: with ERR_CNT_W=4, inject 20 errors with windows reset between them -> err_cnt holds 15. clr asserted together with an error -> err_cnt=0, err_pulse=1.
- Async reset: assert rst mid-LOCKED between clock edges -> locked=0 and err_cnt=0 immediately; relock takes 12 valid bits.
